bcd_7seg_scan: RTL and testbench
================================

// Module: bcd_7seg_scan
// PURPOSE
//  Time-multiplexed driver for a 4-digit common-anode 7-segment display (Basys3-style).
//  Consumes 4 BCD digits (THOUSANDS..ONES) from the binary-to-BCD stage, shadow-buffers them,
//  scans one digit per refresh slot, drives active-low anodes, segments and decimal point.
// PARAMETERS
//  REFRESH_DIV  100_000  CLK cycles per digit slot (>=2); 100 MHz -> 1 kHz/digit, 250 Hz frame
// PORTS
//  CLK        in   1  system clock; single clock domain
//  RST        in   1  reset, synchronous, active-high
//  THOUSANDS  in   4  BCD digit 3 (leftmost, AN[3])
//  HUNDREDS   in   4  BCD digit 2 (AN[2])
//  TENS       in   4  BCD digit 1 (AN[1])
//  ONES       in   4  BCD digit 0 (rightmost, AN[0])
//  LOAD       in   1  1-cycle strobe: capture the 4 digit inputs into the pending register
//  DP_IN      in   4  per-digit decimal point request, active-high; sampled live
//  BLANK      in   1  active-high: all anodes off; scanning continues
//  SEGS       out  7  {CG,CF,CE,CD,CC,CB,CA}, active-low, registered
//  DP         out  1  decimal point, active-low, registered
//  AN         out  4  anode enables, active-low, one-hot-low, registered
// BEHAVIOUR
//  Reset (RST=1 at posedge): AN=4'b1111, SEGS=7'h7F, DP=1, prescaler=0, idx=0, display regs=0,
//    pending regs=0, pend_vld=0. RST mid-scan blanks on the next edge; no partial state retained.
//  Prescaler: counts 0..REFRESH_DIV-1, wraps; tick=1 when count==REFRESH_DIV-1.
//  idx (2b): advances on tick, 0->1->2->3->0. Frame wrap = tick while idx==3.
//  LOAD: pending <= digit inputs, pend_vld <= 1; later LOAD in same frame overwrites (last wins).
//  Frame wrap with pend_vld=1: display <= pending, pend_vld <= 0. LOAD on the wrap cycle
//    bypasses: display <= live inputs that same edge. Display never changes mid-frame (no tearing).
//  Outputs registered from (idx, display, DP_IN, BLANK): 1-cycle latency; first cycle after
//    RST release drives idx 0 (AN=4'b1110).
//  AN = ~(4'b0001 << idx); forced 4'b1111 when BLANK=1 or digit blanked (see CONFIGURATION).
//  SEGS via decoder: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000; 4'hA-4'hF -> '-' = 0111111.
//  DP = ~DP_IN[idx]; DP=1 whenever AN=4'b1111.
// CONFIGURATION
//  Macro BCD_7SEG_LEADING_ZERO_BLANK_EN:
//   defined: digit k (k=3..1) blanked (AN bit 1, SEGS=7'h7F, DP=1) iff display digit k and all
//    higher digits are 0; ONES never blanked ("0000" shows "   0").
//   undefined: all four digits always lit, leading zeros shown.
// STRUCTURE
//  Package seg_pkg: typedef logic [3:0] bcd_t; typedef logic [1:0] dig_idx_t;
//   localparam logic [6:0] SEG_0..SEG_9, SEG_DASH=7'b0111111, SEG_OFF=7'h7F.
//  Sub-module bcd_to_seg (combinational bcd_t -> 7-bit active-low pattern), one instance
//   fed by the idx mux; prescaler, idx, shadow regs, output regs in top.
// TESTING (bench REFRESH_DIV=4, macro undefined unless stated)
//  1 RST held 3 cycles -> AN=1111,SEGS=7F,DP=1; release -> next edge AN=1110, SEGS=1000000.
//  2 LOAD {1,2,3,4} -> unchanged until frame wrap; then 4 cycles each: AN=1110/0011001,
//    1101/0110000, 1011/0100100, 0111/1111001; repeats every 16 cycles.
//  3 LOAD {5,5,5,5} at idx1 then LOAD {9,8,7,6} at idx2 -> only 9876 displayed after wrap;
//    LOAD {1,1,1,1} on wrap-tick cycle -> 1111 shown in the immediately following frame.
//  4 ONES=4'hC, DP_IN=4'b0001 -> idx0 slot SEGS=0111111, DP=0; other slots DP=1.
//  5 Macro defined, LOAD {0,0,4,2} -> AN[3],AN[2] slots AN=1111,SEGS=7F; idx1 '4', idx0 '2';
//    macro undefined -> slots 3,2 show 1000000. BLANK=1 any slot -> AN=1111 next edge.
//  6 RST pulsed at idx2 mid-display -> next edge reset values; pend_vld cleared; shows 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and active-low segment patterns for the 4-digit scanner.
package seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] dig_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low {CG..CA} pattern; non-decimal codes render a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame-aligned shadow update.
// Optional leading-zero blanking: define BCD_7SEG_LEADING_ZERO_BLANK_EN.
module bcd_7seg_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  bcd_t       THOUSANDS,
  input  bcd_t       HUNDREDS,
  input  bcd_t       TENS,
  input  bcd_t       ONES,
  input  logic       LOAD,
  input  logic [3:0] DP_IN,
  input  logic       BLANK,
  output logic [6:0] SEGS,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  dig_idx_t      idx;
  bcd_t [3:0]    disp;
  bcd_t [3:0]    pend;
  bcd_t [3:0]    live;
  logic          pend_vld;
  logic          tick;
  logic          wrap;
  logic [3:0]    lz;
  logic          off;
  logic [6:0]    seg;

  assign live = {THOUSANDS, HUNDREDS, TENS, ONES};
  assign tick = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // Display only changes at frame wrap; a LOAD on that edge goes straight through.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (wrap && LOAD) begin
      disp     <= live;
      pend     <= live;
      pend_vld <= 1'b0;
    end else if (wrap && pend_vld) begin
      disp     <= pend;
      pend_vld <= 1'b0;
    end else if (LOAD) begin
      pend     <= live;
      pend_vld <= 1'b1;
    end
  end

`ifdef BCD_7SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz    = '0;
    lz[3] = (disp[3] == 4'd0);
    lz[2] = lz[3] && (disp[2] == 4'd0);
    lz[1] = lz[2] && (disp[1] == 4'd0);
  end
`else
  assign lz = '0;
`endif

  assign off = BLANK || lz[idx];

  bcd_to_seg u_dec (
    .bcd (disp[idx]),
    .seg (seg)
  );

  always_ff @(posedge CLK) begin
    if (RST || off) begin
      AN   <= 4'b1111;
      SEGS <= SEG_OFF;
      DP   <= 1'b1;
    end else begin
      AN   <= ~(4'b0001 << idx);
      SEGS <= seg;
      DP   <= ~DP_IN[idx];
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Self-checking bench for bcd_7seg_scan (REFRESH_DIV=4) against a frame-level model.
module tb_bcd_7seg_scan;

  localparam int DIV = 4;
  localparam int FRM = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] th = '0, hu = '0, te = '0, on = '0;
  logic       load = 1'b0;
  logic [3:0] dp_in = '0;
  logic       blank = 1'b0;
  logic [6:0] segs;
  logic       dp;
  logic [3:0] an;

  bcd_7seg_scan #(.REFRESH_DIV(DIV)) dut (
    .CLK(clk), .RST(rst),
    .THOUSANDS(th), .HUNDREDS(hu), .TENS(te), .ONES(on),
    .LOAD(load), .DP_IN(dp_in), .BLANK(blank),
    .SEGS(segs), .DP(dp), .AN(an)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int c = 0;
  int shown [4];
  int nxt [4];
  bit have_nxt = 0;
  logic [6:0] segtab [16];

  task automatic chk(input string tag, input logic [6:0] got,
                     input logic [6:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d got=%b exp=%b", tag, c, got, exp);
    end
  endtask

  task automatic model_reset();
    c = 0;
    have_nxt = 0;
    for (int i = 0; i < 4; i++) shown[i] = 0;
  endtask

  // One clock; the output after the edge reflects cycle c's slot and inputs.
  task automatic step();
    int k, val, p10;
    bit lzb;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge clk);
    #1;
    k = (c / DIV) % 4;
    val = shown[3] * 1000 + shown[2] * 100 + shown[1] * 10 + shown[0];
    p10 = (k == 3) ? 1000 : (k == 2) ? 100 : (k == 1) ? 10 : 0;
    lzb = 0;
`ifdef BCD_7SEG_LEADING_ZERO_BLANK_EN
    lzb = (k > 0) && (val < p10);
`endif
    if (blank || lzb) begin
      e_an = 4'b1111;
      e_seg = 7'h7F;
      e_dp = 1'b1;
    end else begin
      e_an = 4'b1111;
      e_an[k] = 1'b0;
      e_seg = segtab[shown[k]];
      e_dp = !dp_in[k];
    end
    chk("an", {3'b0, an}, {3'b0, e_an});
    chk("dp", {6'b0, dp}, {6'b0, e_dp});
    if (!blank) chk("segs", segs, e_seg);
    if (load) begin
      nxt[3] = th; nxt[2] = hu; nxt[1] = te; nxt[0] = on;
      have_nxt = 1;
    end
    if (c % FRM == FRM - 1 && have_nxt) begin
      shown = nxt;
      have_nxt = 0;
    end
    c++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FRM && c % FRM != ph; i++) step();
  endtask

  task automatic do_load(input int a, input int b, input int d,
                         input int e);
    th = 4'(a); hu = 4'(b); te = 4'(d); on = 4'(e);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_an", {3'b0, an}, 7'b0001111);
      chk("rst_segs", segs, 7'h7F);
      chk("rst_dp", {6'b0, dp}, 7'd1);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    model_reset();
    #1;
    hold_reset(3);
    step();
    do_load(1, 2, 3, 4);
    run(40);
    run_to(4);
    do_load(5, 5, 5, 5);
    run_to(8);
    do_load(9, 8, 7, 6);
    run_to(15);
    do_load(1, 1, 1, 1);
    run(20);
    run_to(15);
    do_load(9, 8, 7, 6);
    run(20);
    dp_in = 4'b0001;
    do_load(0, 7, 0, 12);
    run(34);
    dp_in = 4'b0000;
    do_load(0, 0, 4, 2);
    run(34);
    blank = 1'b1;
    run(18);
    blank = 1'b0;
    do_load(4, 3, 2, 1);
    run_to(8);
    run(1);
    hold_reset(1);
    run(34);
    for (int i = 0; i < 320; i++) begin
      th = ($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom_range(0, 15));
      hu = ($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom_range(0, 15));
      te = ($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom_range(0, 15));
      on = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 5) == 0);
      dp_in = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 9) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
